// File: rtl/sha256xmss_arbiter_pkg.sv
// Shared definitions for the sha256XMSS core arbiter.
// Latency: n/a (types, widths and a width helper only).
// Backpressure: n/a.
package sha256xmss_arbiter_pkg;

    localparam int DATA_IN_W  = 1024;   // hash core operand width
    localparam int DATA_OUT_W = 256;    // hash core result width

    // One hash transaction walks IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Grant index width; a single requester still gets a 1-bit index.
    function automatic int grant_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/sha256xmss_arbiter_rr_pick.sv
// Round-robin picker: lowest requester index at or after rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; found is low when the mask is empty.
// Ports: req_mask (eligible requesters), rr_ptr (search start) -> grant (index), found.
module sha256xmss_arbiter_rr_pick
    import sha256xmss_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int REQ_W   = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [REQ_W-1:0]   rr_ptr,
    output logic [REQ_W-1:0]   grant,
    output logic               found
);

    // Scan offsets from farthest to nearest so the nearest set bit
    // (i.e. first one after rr_ptr in wrap order) is the last to assign.
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (req_mask[idx]) begin
                grant = REQ_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256xmss_arbiter.sv
// Shares one sha256XMSS hash core among NUM_REQ requesters, one transaction at a time.
// Latency: grant -> hash_start 1 cycle; hash_done -> req_done 1 cycle; back in IDLE 2 cycles after hash_done.
// Backpressure: requesters hold req_valid + operands until req_done; losers simply wait, lock owner may starve others.
// Ports: io_mainClk/io_systemReset; req_* per-requester operands/controls in, req_done/req_data_out back;
//        hash_* drive the core and take its done/result; grant_id/arb_busy/lock_active are status.
module sha256xmss_arbiter
    import sha256xmss_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int REQ_W   = grant_w(NUM_REQ)
) (
    input  logic                           io_mainClk,
    input  logic                           io_systemReset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_IN_W-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]             req_message_length,
    input  logic [NUM_REQ-1:0]             req_second_block,
    input  logic [NUM_REQ-1:0]             req_store_intermediate,
    input  logic [NUM_REQ-1:0]             req_continue_intermediate,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [DATA_OUT_W-1:0]          req_data_out,
    output logic                           hash_start,
    output logic [DATA_IN_W-1:0]           hash_data_in,
    output logic                           hash_message_length,
    output logic                           hash_second_block,
    output logic                           hash_store_intermediate,
    output logic                           hash_continue_intermediate,
    input  logic                           hash_done,
    input  logic [DATA_OUT_W-1:0]          hash_data_out,
    output logic [REQ_W-1:0]               grant_id,
    output logic                           arb_busy,
    output logic                           lock_active
);

    arb_state_t          state;
    logic [REQ_W-1:0]    rr_ptr;
    logic [REQ_W-1:0]    lock_owner;
    logic [REQ_W-1:0]    pick_id;
    logic                pick_found;
    logic [REQ_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0]  eligible;
    logic                mux_en;

    // While the intermediate-state lock is held only its owner may be granted,
    // so a store/continue sequence never has a foreign hash slipped in between.
    always_comb begin
        eligible = req_valid;
        if (lock_active) begin
            eligible = req_valid & (NUM_REQ'(1) << lock_owner);
        end
    end

    sha256xmss_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_rr_pick (
        .req_mask (eligible),
        .rr_ptr   (rr_ptr),
        .grant    (pick_id),
        .found    (pick_found)
    );

    assign next_ptr = (grant_id == REQ_W'(NUM_REQ - 1)) ? '0 : grant_id + REQ_W'(1);

    // Core inputs follow the owner only while a transaction is in flight;
    // otherwise they are forced to zero so the core never sees stray operands.
    assign mux_en = (state == ST_ISSUE) || (state == ST_WAIT);

    always_comb begin
        hash_data_in               = '0;
        hash_message_length        = 1'b0;
        hash_second_block          = 1'b0;
        hash_store_intermediate    = 1'b0;
        hash_continue_intermediate = 1'b0;
        if (mux_en) begin
            hash_data_in               = req_data_in[grant_id*DATA_IN_W +: DATA_IN_W];
            hash_message_length        = req_message_length[grant_id];
            hash_second_block          = req_second_block[grant_id];
            hash_store_intermediate    = req_store_intermediate[grant_id];
            hash_continue_intermediate = req_continue_intermediate[grant_id];
        end
    end

    always_ff @(posedge io_mainClk) begin
        if (io_systemReset) begin
            state        <= ST_IDLE;
            grant_id     <= '0;
            rr_ptr       <= '0;
            lock_active  <= 1'b0;
            lock_owner   <= '0;
            req_done     <= '0;
            req_data_out <= '0;
            hash_start   <= 1'b0;
            arb_busy     <= 1'b0;
        end else begin
            hash_start <= 1'b0;
            req_done   <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id   <= pick_id;
                        hash_start <= 1'b1;
                        arb_busy   <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Owner dropping req_valid here is ignored: the core is
                    // already running and the result is still handed back.
                    if (hash_done) begin
                        req_data_out <= hash_data_out;
                        req_done     <= NUM_REQ'(1) << grant_id;
                        state        <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    rr_ptr      <= next_ptr;
                    lock_active <= req_store_intermediate[grant_id];
                    if (req_store_intermediate[grant_id]) begin
                        lock_owner <= grant_id;
                    end
                    arb_busy    <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256xmss_arbiter.sv
// Bench for sha256xmss_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sha256xmss_arbiter;

    localparam int N  = 3;
    localparam int RW = 2;
    localparam int DW = 1024;
    localparam int OW = 256;

    // Reference-model transaction phases
    localparam int P_IDLE    = 0;
    localparam int P_ISSUE   = 1;
    localparam int P_WAIT    = 2;
    localparam int P_RELEASE = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data_in;
    logic [N-1:0]    req_message_length;
    logic [N-1:0]    req_second_block;
    logic [N-1:0]    req_store_intermediate;
    logic [N-1:0]    req_continue_intermediate;
    logic [N-1:0]    req_done;
    logic [OW-1:0]   req_data_out;
    logic            hash_start;
    logic [DW-1:0]   hash_data_in;
    logic            hash_message_length;
    logic            hash_second_block;
    logic            hash_store_intermediate;
    logic            hash_continue_intermediate;
    logic            hash_done;
    logic [OW-1:0]   hash_data_out;
    logic [RW-1:0]   grant_id;
    logic            arb_busy;
    logic            lock_active;

    always #5 clk = ~clk;

    sha256xmss_arbiter #(.NUM_REQ(N), .REQ_W(RW)) dut (
        .io_mainClk                 (clk),
        .io_systemReset             (rst),
        .req_valid                  (req_valid),
        .req_data_in                (req_data_in),
        .req_message_length         (req_message_length),
        .req_second_block           (req_second_block),
        .req_store_intermediate     (req_store_intermediate),
        .req_continue_intermediate  (req_continue_intermediate),
        .req_done                   (req_done),
        .req_data_out               (req_data_out),
        .hash_start                 (hash_start),
        .hash_data_in               (hash_data_in),
        .hash_message_length        (hash_message_length),
        .hash_second_block          (hash_second_block),
        .hash_store_intermediate    (hash_store_intermediate),
        .hash_continue_intermediate (hash_continue_intermediate),
        .hash_done                  (hash_done),
        .hash_data_out              (hash_data_out),
        .grant_id                   (grant_id),
        .arb_busy                   (arb_busy),
        .lock_active                (lock_active)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    int            m_phase = P_IDLE;
    int            m_grant = 0;
    int            m_rr    = 0;
    int            m_owner = 0;
    bit            m_lock  = 1'b0;
    logic [OW-1:0] m_result = '0;

    // Core responder
    int            core_cnt    = 0;
    int            core_lat    = 4;
    bit            random_mode = 1'b0;
    bit            spur_once   = 1'b0;
    logic [OW-1:0] core_last   = '0;

    int starts[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (low 160 bits)", tag, got[159:0], exp[159:0]);
        end
    endtask

    function automatic logic [DW-1:0] rand1024();
        logic [DW-1:0] v;
        for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [OW-1:0] rand256();
        logic [OW-1:0] v;
        for (int k = 0; k < OW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // First requester in the cyclic order ptr, ptr+1, ... that is eligible.
    function automatic int rr_winner(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic core_drive();
        hash_done     = 1'b0;
        hash_data_out = rand256();
        if (rst) begin
            core_cnt = 0;
        end else if (m_phase == P_ISSUE) begin
            core_cnt = (core_lat > 0) ? core_lat : int'($urandom_range(1, 12));
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                hash_done = 1'b1;
                core_last = hash_data_out;
            end
        end else if (m_phase == P_IDLE && (spur_once || (random_mode && $urandom_range(0, 15) == 0))) begin
            hash_done = 1'b1;
            spur_once = 1'b0;
        end
    endtask

    // Advances the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        logic [N-1:0] elig;
        int w;
        if (rst) begin
            m_phase = P_IDLE; m_grant = 0; m_rr = 0; m_owner = 0; m_lock = 1'b0; m_result = '0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (!m_lock || i == m_owner);
                    w = rr_winner(elig, m_rr);
                    if (w >= 0) begin
                        m_grant = w;
                        m_phase = P_ISSUE;
                    end
                end
                P_ISSUE: m_phase = P_WAIT;
                P_WAIT: begin
                    if (hash_done) begin
                        m_result = hash_data_out;
                        m_phase  = P_RELEASE;
                    end
                end
                default: begin
                    m_rr   = (m_grant + 1) % N;
                    m_lock = req_store_intermediate[m_grant];
                    if (m_lock) m_owner = m_grant;
                    m_phase = P_IDLE;
                end
            endcase
        end
    endtask

    task automatic compare();
        bit            xfer;
        logic [DW-1:0] exp_d;
        logic [3:0]    exp_c;
        logic [N-1:0]  exp_done;
        xfer     = (m_phase == P_ISSUE) || (m_phase == P_WAIT);
        exp_d    = '0;
        exp_c    = '0;
        exp_done = '0;
        if (xfer) begin
            exp_d = req_data_in[m_grant*DW +: DW];
            exp_c = {req_message_length[m_grant], req_second_block[m_grant],
                     req_store_intermediate[m_grant], req_continue_intermediate[m_grant]};
        end
        if (m_phase == P_RELEASE) exp_done[m_grant] = 1'b1;
        chk("arb_busy",     arb_busy,     m_phase != P_IDLE);
        chk("hash_start",   hash_start,   m_phase == P_ISSUE);
        chk("req_done",     req_done,     exp_done);
        chk("req_data_out", req_data_out, m_result);
        chk("lock_active",  lock_active,  m_lock);
        chk("grant_id",     grant_id,     m_grant);
        chk("hash_data_in", hash_data_in, exp_d);
        chk("hash_ctl",     {hash_message_length, hash_second_block, hash_store_intermediate,
                             hash_continue_intermediate}, exp_c);
        if (hash_start === 1'b1) starts.push_back(int'(grant_id));
    endtask

    task automatic tick();
        core_drive();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set_req(input int i, input bit v, input logic [DW-1:0] d, input bit st, input bit ct);
        req_valid[i]                 = v;
        req_data_in[i*DW +: DW]      = d;
        req_store_intermediate[i]    = st;
        req_continue_intermediate[i] = ct;
        req_message_length[i]        = 1'($urandom_range(0, 1));
        req_second_block[i]          = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        req_valid = '0; req_store_intermediate = '0; req_continue_intermediate = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int who, output int cycles);
        who    = -1;
        cycles = 0;
        while (who < 0 && cycles < budget) begin
            tick();
            cycles++;
            for (int i = 0; i < N; i++) if (req_done[i] === 1'b1) who = i;
        end
        if (who < 0) chk("wait_done_timeout", 0, 1);
    endtask

    task automatic rand_reqs();
        bit owner;
        for (int i = 0; i < N; i++) begin
            owner = (m_phase != P_IDLE) && (m_grant == i);
            if (owner) begin
                if (m_phase == P_WAIT && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                set_req(i, $urandom_range(0, 9) < 7, rand1024(), $urandom_range(0, 3) == 0,
                        1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        int            who;
        int            cyc;
        logic [DW-1:0] a;
        int            exp_seq[3];

        rst = 1'b1;
        req_valid = '0; req_data_in = '0; req_message_length = '0; req_second_block = '0;
        req_store_intermediate = '0; req_continue_intermediate = '0;
        hash_done = 1'b0; hash_data_out = '0;

        // Reset values
        do_reset();
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_lock", lock_active, 0);
        chk("rst_data_out", req_data_out, 0);

        // Single request, core latency 64
        core_lat = 64;
        a = rand1024();
        set_req(0, 1'b1, a, 1'b0, 1'b0);
        tick();
        chk("single_start", hash_start, 1);
        chk("single_operands", hash_data_in, a);
        wait_done(200, who, cyc);
        chk("single_owner", who, 0);
        chk("single_done_latency", cyc, 65);
        chk("single_result", req_data_out, core_last);
        req_valid[0] = 1'b0;
        tick();
        chk("single_busy_low", arb_busy, 0);

        // Contention from reset: 0, 1, 0
        do_reset();
        core_lat = 4;
        set_req(0, 1'b1, rand1024(), 1'b0, 1'b0);
        set_req(1, 1'b1, rand1024(), 1'b0, 1'b0);
        starts.delete();
        for (int k = 0; k < 3; k++) wait_done(100, who, cyc);
        exp_seq = '{0, 1, 0};
        chk("contention_count", starts.size() >= 3, 1);
        for (int k = 0; k < 3 && k < starts.size(); k++) chk($sformatf("contention_grant%0d", k), starts[k], exp_seq[k]);
        tick();
        req_valid = '0;
        tick();

        // Intermediate-state lock
        do_reset();
        set_req(0, 1'b1, rand1024(), 1'b1, 1'b0);
        set_req(1, 1'b1, rand1024(), 1'b0, 1'b0);
        wait_done(100, who, cyc);
        chk("lock_first_owner", who, 0);
        tick();
        chk("lock_set", lock_active, 1);
        req_valid[0] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("lock_starves_others", arb_busy, 0);
        set_req(0, 1'b1, rand1024(), 1'b0, 1'b1);
        wait_done(100, who, cyc);
        chk("lock_owner_regrant", who, 0);
        tick();
        chk("lock_cleared", lock_active, 0);
        req_valid[0] = 1'b0;
        wait_done(100, who, cyc);
        chk("unlock_grant_other", who, 1);
        tick();
        req_valid = '0;
        tick();

        // Reset during WAIT restarts round robin at 0
        do_reset();
        core_lat = 6;
        set_req(0, 1'b1, rand1024(), 1'b0, 1'b0);
        wait_done(100, who, cyc);
        tick();
        req_valid[0] = 1'b0;
        core_lat = 50;
        set_req(1, 1'b1, rand1024(), 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wait_busy", arb_busy, 0);
        chk("rst_wait_no_done", req_done, 0);
        core_lat = 5;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        wait_done(100, who, cyc);
        chk("rst_rr_restart", who, 0);
        tick();
        req_valid = '0;

        // Owner drops req_valid during WAIT, then spurious done in IDLE
        core_lat = 10;
        set_req(2, 1'b1, rand1024(), 1'b0, 1'b0);
        tick();
        tick();
        tick();
        req_valid[2] = 1'b0;
        wait_done(100, who, cyc);
        chk("dropped_valid_done", who, 2);
        tick();
        spur_once = 1'b1;
        tick();
        tick();
        chk("spurious_idle_busy", arb_busy, 0);
        chk("spurious_idle_no_done", req_done, 0);

        // Random traffic
        random_mode = 1'b1;
        core_lat    = 0;
        for (int c = 0; c < 3000; c++) begin
            rand_reqs();
            if (m_phase == P_WAIT && $urandom_range(0, 99) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        random_mode = 1'b0;
        req_valid   = '0;
        req_store_intermediate = '0;
        for (int c = 0; c < 60; c++) tick();
        chk("drain_idle", arb_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256xmss_arbiter.md
# sha256XMSS_arbiter

Round-robin arbiter that shares the single sha256XMSS hash core among NUM_REQ requesters (gen_chain instances, the software command path, later l-tree/treehash engines). It owns the core's control inputs, sequences one hash transaction at a time (issue, wait for done, release), routes the granted requester's operands to the core, and returns done and result to the owner. An intermediate-state lock keeps the core dedicated to one requester across store_intermediate/continue_intermediate sequences.

## Interface
- NUM_REQ, 2: number of requesters, 2..8
- REQ_W, `CLOG2(NUM_REQ)`: grant index width
- io_mainClk  in  1  system clock
- io_systemReset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester level request; held with operands stable until req_done
- req_data_in  in  NUM_REQ*1024  operands; requester i at [1024*i +: 1024]
- req_message_length  in  NUM_REQ  per-requester message_length
- req_second_block  in  NUM_REQ  per-requester second_block_data_available
- req_store_intermediate  in  NUM_REQ  per-requester store_intermediate
- req_continue_intermediate  in  NUM_REQ  per-requester continue_intermediate
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse to owner
- req_data_out  out  256  result, valid with req_done, held until next completion
- hash_start  out  1  one-cycle start pulse to core
- hash_data_in  out  1024  muxed operands
- hash_message_length, hash_second_block, hash_store_intermediate, hash_continue_intermediate  out  1 each  muxed controls
- hash_done  in  1  core done pulse
- hash_data_out  in  256  core result
- grant_id  out  REQ_W  current owner index
- arb_busy  out  1  high in any state except IDLE
- lock_active  out  1  intermediate-state lock held

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
- IDLE: if any eligible req_valid, pick winner, register grant_id, go ISSUE. Eligible = all requesters when unlocked; only lock_owner when lock_active.
- Pick: round-robin; search starts at rr_ptr, ascending, wrap at NUM_REQ-1 -> 0. Lowest index at or after rr_ptr wins.
- ISSUE: hash_start=1 for exactly this cycle; go WAIT.
- WAIT: hold muxed operands/controls from grant_id; on hash_done register hash_data_out into req_data_out, go RELEASE.
- RELEASE: req_done[grant_id]=1; rr_ptr <= grant_id+1 (wrap); lock update; go IDLE.
- Lock update in RELEASE: granted store_intermediate=1 -> lock_active=1, lock_owner=grant_id; else lock_active=0.
- Mux outputs driven from grant_id in ISSUE and WAIT; all hash_* controls 0 and hash_data_in 0 in IDLE/RELEASE.
- req_valid dropped while granted: ignored; transaction completes, req_done still pulses (no abort).
- hash_done outside WAIT: ignored.
- Locked and owner idle: other requesters starve until owner issues a non-store transaction; intended.

## Timing
- Reset: state IDLE, grant_id 0, rr_ptr 0, lock_active 0, lock_owner 0, req_done 0, req_data_out 0, hash_start 0, all hash_* 0, arb_busy 0.
- req_valid sampled in IDLE at cycle t -> ISSUE/hash_start at t+1 -> WAIT from t+2.
- hash_done at cycle d (in WAIT) -> req_done and req_data_out valid at d+1 -> IDLE at d+2.
- Requester deasserts req_valid (or presents the next operation) by cycle d+2; arbiter samples in IDLE at d+2. Back-to-back from same requester: minimum 3 cycles overhead plus core latency.
- Simultaneous requests in IDLE: round-robin winner only; losers keep req_valid high, no side effects.
- Reset mid-transaction: immediate return to reset values next cycle; no req_done pulse; core shares reset.

## Structure
- Shared header: FSM state encodings (2-bit), data widths (1024/256), REQ_W derivation.
- Sub-module rr_pick: combinational round-robin picker (req mask, rr_ptr) -> grant index + found flag.
- Top holds FSM, lock registers, output registers, operand mux.

## Test plan
- Single request: req_valid=01, data A, hash_done 64 cycles after hash_start -> hash_start at t+1 with A, req_done=01 at d+1, req_data_out=core value, arb_busy back low at d+2.
- Contention: req_valid=11 from reset -> grant 0 first, then 1, then 0; grant_id sequence 0,1,0 with rr_ptr wrap.
- Lock: req 0 store_intermediate=1 while req 1 pending -> next grant stays 0 (lock_active=1); req 0 continue with store=0 -> lock clears, req 1 granted next.
- Mux isolation: while granted 1, toggle req 0 operands -> hash_data_in equals req 1 data every ISSUE/WAIT cycle; all hash_* 0 in IDLE/RELEASE.
- Reset in WAIT: assert io_systemReset one cycle -> all outputs reset values, no req_done, next request granted from rr_ptr 0.
- Spurious hash_done in IDLE and req_valid dropped during WAIT -> no state change; transaction still ends with req_done.
